// File: rtl/cdb_arbiter.sv
// Round-robin arbiter feeding a registered common-data-bus broadcast stage.
// Optional stall counter is built when CDB_PERF_EN is defined.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 33,
  parameter int TAG_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     cdb_valid,
  output logic [WIDTH-1:0]         cdb_data,
  output logic [TAG_W-1:0]         cdb_tag,
  input  logic                     cdb_stall
`ifdef CDB_PERF_EN
  ,
  output logic [15:0]              perf_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   scan_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any_req;
  logic               load;
  int                 idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
      assign tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
    end
  endgenerate

  // The grant only looks at req_valid, never at the offered data or tag.
  always_comb begin
    grant    = '0;
    win_idx  = '0;
    any_req  = 1'b0;
    idx      = 0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      scan_idx = PTR_W'(idx);
      if (!any_req && req_valid[scan_idx]) begin
        any_req         = 1'b1;
        grant[scan_idx] = 1'b1;
        win_idx         = scan_idx;
      end
    end
  end

  assign next_ptr  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign load      = !flush && (!cdb_valid || !cdb_stall);
  assign req_ready = (load && !reset) ? grant : '0;

  // Data/tag flops are enable-gated: they only change when a winner is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (load) begin
      cdb_valid <= any_req;
      if (any_req) begin
        cdb_data <= data_arr[win_idx];
        cdb_tag  <= tag_arr[win_idx];
        rr_ptr   <= next_ptr;
      end
    end
  end

`ifdef CDB_PERF_EN
  logic transfer;
  assign transfer = |(req_valid & req_ready);

  // Counts pending-but-refused cycles; survives flush, saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if (|req_valid && !transfer && perf_stall_cnt != 16'hFFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, grant order, backpressure, flush
// and (when CDB_PERF_EN is defined) the stall counter.
module tb_cdb_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 33;
  localparam int TAG_W   = 5;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     cdb_valid;
  logic [WIDTH-1:0]         cdb_data;
  logic [TAG_W-1:0]         cdb_tag;
  logic                     cdb_stall;
`ifdef CDB_PERF_EN
  logic [15:0]              perf_stall_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_tag(req_tag),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid),
    .cdb_data(cdb_data),
    .cdb_tag(cdb_tag),
    .cdb_stall(cdb_stall)
`ifdef CDB_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
    $display("check %-22s observed %h expected %h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t);
    req_data[i*WIDTH +: WIDTH] = d;
    req_tag[i*TAG_W +: TAG_W]  = t;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    cdb_stall = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    req_tag   = '0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    tick();
    tick();
    chk("rst_data", 64'(cdb_data), 64'h0);
    chk("rst_tag", 64'(cdb_tag), 64'h0);
    reset     = 1'b0;
    req_valid = 4'b0000;

    // Load one broadcast, then reset in the middle of the cycle.
    set_req(0, 33'h0_0000_00AA, 5'd9);
    req_valid = 4'b0001;
    #1;
    chk("a_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    chk("a_valid", 64'(cdb_valid), 64'h1);
    chk("a_tag", 64'(cdb_tag), 64'd9);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(cdb_valid), 64'h0);
    chk("async_rst_data", 64'(cdb_data), 64'h0);
    chk("async_rst_tag", 64'(cdb_tag), 64'h0);
    chk("async_rst_ready", 64'(req_ready), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'h0);

    // Single requester 2 from rr_ptr=0.
    set_req(2, 33'h1_2345_6789, 5'd17);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(req_ready), 64'h4);
    tick();
    chk("single_valid", 64'(cdb_valid), 64'h1);
    chk("single_data", 64'(cdb_data), 64'h1_2345_6789);
    chk("single_tag", 64'(cdb_tag), 64'd17);

    // rr_ptr should now be 3: requesters 0,1,3 pending picks 3.
    set_req(3, 33'h0_DEAD_BEEF, 5'd30);
    req_valid = 4'b1011;
    #1;
    chk("ptr3_ready", 64'(req_ready), 64'h8);
    tick();
    chk("ptr3_tag", 64'(cdb_tag), 64'd30);
    chk("ptr3_data", 64'(cdb_data), 64'h0_DEAD_BEEF);

    // Round robin with all four pending, starting from rr_ptr=0.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 33'h1_0000_0100 + 33'(i), 5'(20 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr%0d_tag", k), 64'(cdb_tag), 64'(20 + (k % 4)));
      chk($sformatf("rr%0d_data", k), 64'(cdb_data), 64'h1_0000_0100 + 64'(k % 4));
    end

    // Backpressure: broadcast tag 3 from requester 0, then stall.
    set_req(0, 33'h0_0000_0033, 5'd3);
    req_valid = 4'b0001;
    tick();
    chk("bp_tag0", 64'(cdb_tag), 64'd3);
    cdb_stall = 1'b1;
    req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'h0);
      tick();
      chk($sformatf("bp%0d_valid", k), 64'(cdb_valid), 64'h1);
      chk($sformatf("bp%0d_tag", k), 64'(cdb_tag), 64'd3);
    end
    cdb_stall = 1'b0;
    #1;
    chk("bp_rel_ready", 64'(req_ready), 64'h2);
    tick();
    chk("bp_rel_tag", 64'(cdb_tag), 64'd21);
    chk("bp_rel_data", 64'(cdb_data), 64'h1_0000_0101);

    // Idle load: valid drops, data/tag held.
    req_valid = 4'b0000;
    tick();
    chk("idle_valid2", 64'(cdb_valid), 64'h0);
    chk("idle_hold_data", 64'(cdb_data), 64'h1_0000_0101);
    chk("idle_hold_tag", 64'(cdb_tag), 64'd21);

    // Stall while the stage is empty does not block loading (rr_ptr=2).
    cdb_stall = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("stall_empty_ready", 64'(req_ready), 64'h4);
    tick();
    chk("stall_empty_tag", 64'(cdb_tag), 64'd22);

    // Flush beats stall and requests; rr_ptr stays 3.
    flush     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("flush_ready", 64'(req_ready), 64'h0);
    tick();
    chk("flush_valid", 64'(cdb_valid), 64'h0);
    chk("flush_hold_tag", 64'(cdb_tag), 64'd22);
    flush     = 1'b0;
    cdb_stall = 1'b0;
    #1;
    chk("post_flush_ready", 64'(req_ready), 64'h8);
    tick();
    chk("post_flush_tag", 64'(cdb_tag), 64'd23);
    chk("post_flush_data", 64'(cdb_data), 64'h1_0000_0103);

    // Flush without stall; rr_ptr (0) held across it.
    flush = 1'b1;
    #1;
    chk("flush2_ready", 64'(req_ready), 64'h0);
    tick();
    chk("flush2_valid", 64'(cdb_valid), 64'h0);
    flush = 1'b0;
    #1;
    chk("post_flush2_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;

`ifdef CDB_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("perf_rst", 64'(perf_stall_cnt), 64'h0);
    req_valid = 4'b0001;
    tick();
    cdb_stall = 1'b1;
    req_valid = 4'b1111;
    repeat (5) tick();
    flush = 1'b1;
    repeat (2) tick();
    flush     = 1'b0;
    cdb_stall = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("perf_seven", 64'(perf_stall_cnt), 64'd7);
    tick();
    req_valid = 4'b0001;
    tick();
    cdb_stall = 1'b1;
    repeat (65530) tick();
    chk("perf_sat", 64'(perf_stall_cnt), 64'hFFFF);
    repeat (3) tick();
    chk("perf_sat_hold", 64'(perf_stall_cnt), 64'hFFFF);
    cdb_stall = 1'b0;
    req_valid = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
